// File: rtl/tile_reset_sequencer.sv
// Per-tile reset sequencer: ASSERT/RELEASE/PULSE commands; accepts only when idle, done pulses 1 cycle after assert, release is hold+staggered.
// Define TILE_RESET_SEQ_STAGGER_EN for one-tile-per-STAGGER_CYCLES release; default build releases all pending tiles on one edge.
module tile_reset_sequencer #(
  parameter int NUM_TILES      = 6,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_bits_op,
  input  logic [NUM_TILES-1:0] req_bits_mask,
  output logic [NUM_TILES-1:0] tile_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 done_err
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] OP_ASSERT  = 2'd0;
  localparam logic [1:0] OP_RELEASE = 2'd1;
  localparam logic [1:0] OP_PULSE   = 2'd2;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  logic [1:0]           state;
  logic [CW-1:0]        count;
  logic [NUM_TILES-1:0] pending;

`ifdef TILE_RESET_SEQ_STAGGER_EN
  localparam logic [CW-1:0] STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
  logic [NUM_TILES-1:0] low_bit;
  // Isolates the lowest set bit so tiles release in ascending index order.
  assign low_bit = pending & (~pending + NUM_TILES'(1));
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      pending    <= '0;
      tile_reset <= '1;
      done_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            case (req_bits_op)
              OP_ASSERT: begin
                tile_reset <= tile_reset | req_bits_mask;
                state      <= ST_DONE;
              end
              OP_PULSE: begin
                // pending carries the command mask through HOLD
                tile_reset <= tile_reset | req_bits_mask;
                pending    <= req_bits_mask;
                count      <= HOLD_LOAD;
                state      <= ST_HOLD;
              end
              OP_RELEASE: begin
                pending <= req_bits_mask & tile_reset;
                count   <= '0;
                state   <= ST_RELEASE;
              end
              default: begin
                done_err <= 1'b1;
                state    <= ST_DONE;
              end
            endcase
          end
        end
        ST_HOLD: begin
          if (count == '0) begin
            pending <= pending & tile_reset;
            state   <= ST_RELEASE;
          end else begin
            count <= count - CW'(1);
          end
        end
        ST_RELEASE: begin
`ifdef TILE_RESET_SEQ_STAGGER_EN
          if (count != '0) begin
            count <= count - CW'(1);
          end else if (pending == '0) begin
            state <= ST_DONE;
          end else begin
            tile_reset <= tile_reset & ~low_bit;
            pending    <= pending & ~low_bit;
            count      <= STAGGER_LOAD;
            if ((pending & ~low_bit) == '0) state <= ST_DONE;
          end
`else
          tile_reset <= tile_reset & ~pending;
          pending    <= '0;
          state      <= ST_DONE;
`endif
        end
        default: begin
          state    <= ST_IDLE;
          count    <= '0;
          pending  <= '0;
          done_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Randomized self-checking bench; expected reset trajectories come from the command timing rules.
module tb_tile_reset_sequencer;
  localparam int N = 6;
  localparam int H = 16;
  localparam int S = 4;
`ifdef TILE_RESET_SEQ_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_bits_op = 2'd0;
  logic [N-1:0] req_bits_mask = '0;
  logic [N-1:0] tile_reset;
  logic         busy;
  logic         done;
  logic         done_err;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] model_tr;

  tile_reset_sequencer #(
    .NUM_TILES(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits_op(req_bits_op), .req_bits_mask(req_bits_mask),
    .tile_reset(tile_reset), .busy(busy), .done(done), .done_err(done_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the first idle cycle.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] mask,
                       input bit nv, input logic [1:0] nop, input logic [N-1:0] nmask);
    logic [N-1:0] cur, base, rel, exp;
    int rel_t[N];
    int start, k, len, waited;
    bit err;
    req_valid = 1'b1;
    req_bits_op = op;
    req_bits_mask = mask;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    cur = model_tr;
    err = (op == 2'd3);
    start = (op == 2'd2) ? H : 0;
    base = (op == 2'd0 || op == 2'd2) ? (cur | mask) : cur;
    rel = (op == 2'd1 || op == 2'd2) ? (mask & base) : '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      rel_t[i] = 0;
      if (rel[i]) begin
        rel_t[i] = start + 2 + (STAG ? k * S : 0);
        k++;
      end
    end
    if (op == 2'd0 || op == 2'd3) len = 1;
    else if (k == 0) len = start + 2;
    else len = start + 2 + (STAG ? (k - 1) * S : 0);
    exp = base;
    for (int c = 1; c <= len; c++) begin
      @(negedge clock);
      if (c == 1) begin
        req_valid = nv;
        req_bits_op = nop;
        req_bits_mask = nmask;
      end
      exp = base;
      for (int i = 0; i < N; i++)
        if (rel[i] && rel_t[i] <= c) exp[i] = 1'b0;
      check($sformatf("tile_reset op%0d c%0d", op, c), 32'(tile_reset), 32'(exp));
      check($sformatf("done op%0d c%0d", op, c), 32'(done), (c == len) ? 1 : 0);
      check($sformatf("done_err op%0d c%0d", op, c), 32'(done_err), (err && c == len) ? 1 : 0);
      check($sformatf("busy op%0d c%0d", op, c), 32'(busy), 1);
      check($sformatf("req_ready op%0d c%0d", op, c), 32'(req_ready), 0);
    end
    @(negedge clock);
    check("idle req_ready", 32'(req_ready), 1);
    check("idle busy", 32'(busy), 0);
    check("idle done", 32'(done), 0);
    check("idle tile_reset", 32'(tile_reset), 32'(exp));
    model_tr = exp;
  endtask

  initial begin
    logic [1:0]   rop;
    logic [N-1:0] rmask;
    model_tr = '1;
    repeat (3) @(negedge clock);
    check("rst tile_reset", 32'(tile_reset), 32'({N{1'b1}}));
    check("rst req_ready", 32'(req_ready), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst done_err", 32'(done_err), 0);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst tile_reset", 32'(tile_reset), 32'({N{1'b1}}));

    issue(2'd1, 6'h3F, 1'b0, 2'd0, '0);
    issue(2'd2, 6'h05, 1'b0, 2'd0, '0);
    issue(2'd0, 6'h10, 1'b0, 2'd0, '0);
    issue(2'd3, 6'h3F, 1'b0, 2'd0, '0);
    // Second command held valid throughout the pulse, accepted on the first idle cycle.
    issue(2'd2, 6'h03, 1'b1, 2'd1, 6'h3F);
    issue(2'd1, 6'h3F, 1'b0, 2'd0, '0);

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      rmask = N'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue(rop, rmask, 1'b0, 2'd0, '0);
    end

    issue(2'd0, 6'h3F, 1'b0, 2'd0, '0);
    req_valid = 1'b1;
    req_bits_op = 2'd1;
    req_bits_mask = 6'h3F;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (9) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst tile_reset", 32'(tile_reset), 32'({N{1'b1}}));
    check("midrst busy", 32'(busy), 0);
    check("midrst req_ready", 32'(req_ready), 1);
    check("midrst done", 32'(done), 0);
    repeat (3) begin
      @(negedge clock);
      check("in-rst done", 32'(done), 0);
    end
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      check("after-rst done", 32'(done), 0);
      check("after-rst tile_reset", 32'(tile_reset), 32'({N{1'b1}}));
      check("after-rst busy", 32'(busy), 0);
    end
    model_tr = '1;
    issue(2'd1, 6'h2A, 1'b0, 2'd0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_reset_sequencer.md
# tile_reset_sequencer

Command-driven sequencer for per-tile reset lines in the subsystem's tile-reset domain. It takes assert, release and pulse commands over a valid/ready port from the register front end. Each command carries a tile mask. The block drives one reset line per tile, enforces a minimum hold time and releases tiles one at a time with a fixed stagger to limit inrush and bus contention.

## Interface
- `NUM_TILES`, default 6: number of tile reset lines, 1..32.
- `HOLD_CYCLES`, default 16: minimum cycles a PULSE holds reset, ≥1.
- `STAGGER_CYCLES`, default 4: cycles between successive tile releases, ≥1.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high; all state clears immediately.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when `req_valid & req_ready`.
- `req_bits_op`  in  2  0=ASSERT, 1=RELEASE, 2=PULSE, 3=reserved.
- `req_bits_mask`  in  NUM_TILES  tiles targeted; bit i = tile i.
- `tile_reset`  out  NUM_TILES  registered reset per tile, 1 = held in reset.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `done_err`  out  1  valid with `done`; 1 for reserved op.

## Operation
- Reset values:
  - `tile_reset` = all ones (tiles held in reset at power-on).
  - `req_ready` = 1, `busy` = 0, `done` = 0, `done_err` = 0.
  - State = IDLE, counter = 0, pending = 0.
- States: IDLE, HOLD, RELEASE, DONE.
- `req_ready` = (state == IDLE). Commands offered in any other state are not accepted. The requester holds them; they are never dropped.
- IDLE, on accept:
  - ASSERT: `tile_reset |= mask`; go to DONE.
  - PULSE: `tile_reset |= mask`; counter = HOLD_CYCLES-1; go to HOLD.
  - RELEASE: pending = mask & `tile_reset`; counter = 0; go to RELEASE.
  - Reserved: no output change; `done_err` latched 1; go to DONE.
- HOLD: decrement the counter each cycle. When counter == 0: pending = latched mask & `tile_reset`, counter = 0, go to RELEASE.
- RELEASE: each cycle with counter == 0 and pending ≠ 0:
  - clear the lowest-index pending bit in both pending and `tile_reset`;
  - counter = STAGGER_CYCLES-1.
  - Otherwise decrement the counter while it is non-zero.
  - Leave for DONE on the same edge that clears the last pending bit, or immediately if pending == 0.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE and clear `done_err`.
- Tiles outside the mask are never modified. Releasing a tile that is already released is a no-op and adds no stagger slot.
- Counter width is clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The counter never wraps.
- Reset asserted mid-sequence: all tiles return to reset immediately (asynchronously), state returns to IDLE and any in-flight command is discarded.

## Timing
- Cycle 0 = accept cycle.
- ASSERT: new `tile_reset` visible in cycle 1, same cycle as `done`; `req_ready` returns in cycle 2.
- RELEASE with k pending tiles, k ≥ 1:
  - tile j (j-th lowest pending) goes low in cycle 2 + (j-1)·STAGGER_CYCLES;
  - `done` is asserted in the cycle the last tile goes low.
- RELEASE with k = 0: `done` in cycle 2.
- PULSE:
  - mask tiles high from cycle 1;
  - first release visible in cycle HOLD_CYCLES+2, then stagger as above.
- Latency is deterministic. There is no stall source other than `req_valid`.

## Configuration
- `TILE_RESET_SEQ_STAGGER_EN` defined: staggered release as described above.
- `TILE_RESET_SEQ_STAGGER_EN` undefined:
  - RELEASE clears all pending bits on a single edge;
  - those tiles go low in cycle 2 of a RELEASE command, or cycle HOLD_CYCLES+2 of a PULSE, with `done` in that same cycle;
  - `STAGGER_CYCLES` is ignored.

## Test plan
- Reset deassert, then RELEASE with mask 0x3F (defaults) → tiles 0..5 go low in cycles 2, 6, 10, 14, 18, 22; `done` in cycle 22; `req_ready` in cycle 23.
- PULSE with mask 0x05 on all-released tiles → bits 0 and 2 high cycles 1–17; tile0 low at cycle 18, tile2 low at 22; `done` at 22; tiles 1, 3, 4, 5 stay 0 throughout.
- ASSERT with mask 0x10 → `tile_reset` = 0x10 in cycle 1 with `done`, `done_err` = 0.
- Op 3 with mask 0x3F → `tile_reset` unchanged; `done` = 1 and `done_err` = 1 in cycle 1.
- `req_valid` held high during a PULSE → not accepted until the first IDLE cycle; the second command starts exactly then.
- `reset` asserted at cycle 10 of a RELEASE 0x3F → `tile_reset` = 0x3F immediately, `busy` = 0, `done` never pulses.
